// File: rtl/accu_pkg.sv
// Shared constants and helpers for the accumulate/average datapath.
//   SUM_W      : width of an upstream batch sum (four 8-bit samples)
//   AVG_W      : width of a stored/emitted average
//   FIFO_DEPTH : default number of FIFO entries
//   round_sat  : rounded divide-by-four with saturation to the AVG_W range
package accu_pkg;

    localparam int unsigned SUM_W      = 10;
    localparam int unsigned AVG_W      = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [AVG_W-1:0] avg_t;

    // Largest representable average, held at the widened intermediate width.
    localparam logic [SUM_W:0] AVG_MAX = (SUM_W+1)'((1 << AVG_W) - 1);

    // (sum + 2) >> 2 in SUM_W+1 bits so the +2 bias cannot wrap; a full-scale
    // sum rounds up to 256, which is clamped back to 255.
    function automatic avg_t round_sat(input sum_t sum);
        logic [SUM_W:0] biased;
        logic [SUM_W:0] shifted;
        biased  = {1'b0, sum} + (SUM_W+1)'(2);
        shifted = biased >> 2;
        if (shifted > AVG_MAX) begin
            return {AVG_W{1'b1}};
        end
        return shifted[AVG_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and full/empty control for a synchronous FIFO whose
// storage lives in the parent.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_req_i  : producer offers data
//   pop_req_i   : consumer will take data
//   push_o      : a write happens this cycle (write storage at wr_ptr_o)
//   ready_o     : space available (independent of pop_req_i)
//   valid_o     : at least one entry held
//   wr_ptr_o    : tail index
//   rd_ptr_o    : head index
//   level_o     : occupancy, 0..Depth
module sync_fifo_ctrl #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned LvlW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_req_i,
    input  logic            pop_req_i,
    output logic            push_o,
    output logic            ready_o,
    output logic            valid_o,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic [LvlW-1:0] level_o
);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            full, empty;
    logic            push, pop;

    always_comb begin
        full  = (level_q == LvlW'(Depth));
        empty = (level_q == '0);
        // Acceptance looks only at occupancy: a full FIFO refuses data even
        // when the head is being popped in the same cycle.
        push  = push_req_i && !full;
        pop   = pop_req_i && !empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign push_o   = push;
    assign ready_o  = !full;
    assign valid_o  = !empty;
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign level_o  = level_q;

endmodule

// File: rtl/avg_fifo.sv
// FIFO of rounded batch averages. Each accepted 10-bit batch sum is reduced
// to an 8-bit rounded, saturated average at push time; only that byte is kept.
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : upstream batch sum (SUM_W bits)
//   valid_a    : upstream data valid
//   ready_a    : FIFO has space
//   valid_b    : data_out holds the head entry
//   ready_b    : downstream takes the head entry
//   data_out   : head average (undefined while valid_b is low)
//   level      : occupancy, 0..DEPTH
module avg_fifo
    import accu_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SUM_W-1:0]         data_in,
    input  logic                     valid_a,
    output logic                     ready_a,
    output logic                     valid_b,
    input  logic                     ready_b,
    output logic [AVG_W-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic            push;
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    avg_t            avg_d;

    // Storage is deliberately not reset; valid_b qualifies data_out.
    avg_t            mem_q [DEPTH];

    sync_fifo_ctrl #(
        .Depth (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_req_i (valid_a),
        .pop_req_i  (ready_b),
        .push_o     (push),
        .ready_o    (ready_a),
        .valid_o    (valid_b),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .level_o    (level)
    );

    always_comb begin
        avg_d = round_sat(data_in);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= avg_d;
        end
    end

    // Registered storage read by the head pointer: no fall-through path.
    assign data_out = mem_q[rd_ptr];

endmodule

// File: tb/tb_avg_fifo.sv
// Self-checking bench for avg_fifo: directed scenarios plus a random-stall
// soak, all compared against a queue-based reference model.
module tb_avg_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [9:0]    data_in;
    logic          valid_a;
    logic          ready_a;
    logic          valid_b;
    logic          ready_b;
    logic [7:0]    data_out;
    logic [LW-1:0] level;

    int tests;
    int fails;
    logic [7:0] model_q[$];

    avg_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_a  (valid_a),
        .ready_a  (ready_a),
        .valid_b  (valid_b),
        .ready_b  (ready_b),
        .data_out (data_out),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rounded quarter of the batch sum, clamped to a byte.
    function automatic logic [7:0] ref_avg(input int sum);
        int a;
        a = (sum + 2) / 4;
        if (a > 255) a = 255;
        return 8'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(model_q.size()));
        chk({tag, ".valid_b"}, 32'(valid_b), 32'(model_q.size() != 0));
        chk({tag, ".ready_a"}, 32'(ready_a), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            chk({tag, ".data_out"}, 32'(data_out), 32'(model_q[0]));
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, check.
    task automatic step(input logic va, input int d, input logic rb, input string tag);
        logic push_m, pop_m;
        valid_a = va;
        data_in = d[9:0];
        ready_b = rb;
        push_m  = va && (model_q.size() < DEPTH);
        pop_m   = rb && (model_q.size() > 0);
        @(posedge clk);
        if (pop_m) void'(model_q.pop_front());
        if (push_m) model_q.push_back(ref_avg(d));
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (model_q.size() != 0 && guard < 4 * DEPTH) begin
            step(1'b0, 0, 1'b1, tag);
            guard++;
        end
        chk({tag, ".drained"}, 32'(level), 32'(0));
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b1;
        valid_a = 1'b0;
        data_in = '0;
        ready_b = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: 400 -> 100, visible only after the edge, then popped.
        valid_a = 1'b1;
        data_in = 10'd400;
        #1 chk("no_fallthru.valid_b", 32'(valid_b), 32'(0));
        step(1'b1, 400, 1'b0, "basic_push");
        chk("basic.data_out", 32'(data_out), 32'(100));
        chk("basic.level1", 32'(level), 32'(1));
        step(1'b0, 0, 1'b1, "basic_pop");
        chk("basic.level0", 32'(level), 32'(0));

        // Rounding and saturation.
        step(1'b1, 1021, 1'b0, "round_a");
        step(1'b1, 1022, 1'b0, "round_b");
        step(1'b1, 1023, 1'b0, "round_c");
        step(1'b1, 6, 1'b0, "round_d");
        chk("round.head0", 32'(data_out), 32'(255));
        step(1'b0, 0, 1'b1, "round_pop0");
        chk("round.head1", 32'(data_out), 32'(255));
        step(1'b0, 0, 1'b1, "round_pop1");
        chk("round.head2", 32'(data_out), 32'(255));
        step(1'b0, 0, 1'b1, "round_pop2");
        chk("round.head3", 32'(data_out), 32'(2));
        step(1'b0, 0, 1'b1, "round_pop3");

        // Full: four pushes, fifth refused, then drain in order.
        step(1'b1, 4, 1'b0, "full_p0");
        step(1'b1, 8, 1'b0, "full_p1");
        step(1'b1, 12, 1'b0, "full_p2");
        step(1'b1, 16, 1'b0, "full_p3");
        chk("full.level", 32'(level), 32'(4));
        chk("full.ready_a", 32'(ready_a), 32'(0));
        step(1'b1, 100, 1'b0, "full_p4");
        chk("full.refused_level", 32'(level), 32'(4));
        // Full FIFO plus simultaneous pop: the push is still refused.
        step(1'b1, 200, 1'b1, "full_pushpop");
        chk("full.pushpop_level", 32'(level), 32'(3));
        chk("full.head_after", 32'(data_out), 32'(2));
        drain("full_drain");

        // Simultaneous push/pop at level 2 across pointer wrap.
        step(1'b1, 40, 1'b0, "pp_fill0");
        step(1'b1, 44, 1'b0, "pp_fill1");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 48 + 4 * i, 1'b1, "pp_run");
            chk("pp.level", 32'(level), 32'(2));
            chk("pp.head", 32'(data_out), 32'(11 + i));
        end
        drain("pp_drain");

        // Reset mid-operation at level 3, between clock edges.
        step(1'b1, 100, 1'b0, "rst_fill0");
        step(1'b1, 200, 1'b0, "rst_fill1");
        step(1'b1, 300, 1'b0, "rst_fill2");
        chk("rst.level_before", 32'(level), 32'(3));
        valid_a = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("rst.level", 32'(level), 32'(0));
        chk("rst.valid_b", 32'(valid_b), 32'(0));
        chk("rst.ready_a", 32'(ready_a), 32'(1));
        #1 rst_n = 1'b1;
        step(1'b1, 40, 1'b0, "rst_push");
        chk("rst.data_out", 32'(data_out), 32'(10));
        drain("rst_drain");

        // Random-stall soak.
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), "soak");
        end
        drain("soak_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avg_fifo.md
AVG_FIFO -- requirements
Module: avg_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries, a power of two of at least 2.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 SHALL have port data_in, input, 10, the upstream batch sum (a sum of four 8-bit samples).
REQ-005 SHALL have port valid_a, input, 1, upstream data valid.
REQ-006 SHALL have port ready_a, output, 1, this block can accept data.
REQ-007 SHALL have port valid_b, output, 1, data_out is valid.
REQ-008 SHALL have port ready_b, input, 1, downstream accepts data.
REQ-009 SHALL have port data_out, output, 8, the rounded average of the head entry.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1, the current occupancy, from 0 to DEPTH.

Function
REQ-011 SHALL define push as valid_a && ready_a, and pop as valid_b && ready_b.
REQ-012 SHALL drive ready_a = (level != DEPTH); ready_a SHALL NOT depend on ready_b, so a full FIFO does not accept data even when a pop occurs in the same cycle.
REQ-013 SHALL drive valid_b = (level != 0).
REQ-014 SHALL compute the stored value at push time as avg = (data_in + 2) >> 2, using 11-bit intermediate arithmetic, saturated to 255 when the result exceeds 255.
REQ-015 SHALL store only the 8-bit avg; the raw 10-bit sum is not retained.
REQ-016 SHALL add no fall-through path: an entry pushed in cycle N is first visible on data_out and valid_b in cycle N+1.
REQ-017 SHALL drive data_out from the head entry whenever valid_b=1, and hold it stable until a pop occurs.
REQ-018 SHALL use write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-019 SHALL update level as follows: push only gives +1, pop only gives -1, both in the same cycle gives no change, neither gives no change.
REQ-020 SHALL, on a simultaneous push and pop at any level from 1 to DEPTH-1, write the tail and advance the head in the same cycle.
REQ-021 SHALL ignore data_in whenever push=0, leaving state unchanged.
REQ-022 SHALL let data_out be any value when valid_b=0; the bench SHALL NOT check data_out in that case.

Reset
REQ-023 SHALL, while rst_n=0, immediately clear level, both pointers and valid_b to 0, and drive ready_a to 1.
REQ-024 SHALL, when rst_n asserts mid-operation, discard all stored entries without emitting any partial output.
REQ-025 SHALL not require storage contents to be reset; data_out SHALL read 0 after reset only if the storage array is reset.
REQ-026 SHALL accept a push in the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL take constants SUM_W=10, AVG_W=8 and the default DEPTH=4 from a shared package, accu_pkg, which the accumulator stage SHALL also use.
REQ-028 SHALL implement the rounding and saturation function (REQ-014) as a package function, not as a separate module.
REQ-029 SHALL instantiate exactly one sub-module, sync_fifo_ctrl, holding the pointers, level and full/empty logic, with the storage array kept in avg_fifo.

Verification
REQ-030 SHALL cover the basic case: push data_in=400 with ready_b=0, then ready_b=1 -> valid_b rises the next cycle, data_out=100, level goes 1 then 0 after the pop.
REQ-031 SHALL cover rounding and saturation: push 1021, 1022, 1023 and 6 -> data_out 255, 255, 255, 2 in order.
REQ-032 SHALL cover the full condition: ready_b=0, four pushes of 4, 8, 12 and 16 -> level=4, ready_a=0, and a fifth valid_a is not accepted; then drain -> data_out 1, 2, 3, 4.
REQ-033 SHALL cover simultaneous push and pop: at level=2, assert push and pop together for 10 cycles with incrementing data -> level stays 2 and the output order is preserved across pointer wrap-around.
REQ-034 SHALL cover reset mid-operation: at level=3, pulse rst_n low between clock edges -> level=0, valid_b=0 and ready_a=1 immediately, and the next push of 40 yields data_out=10.
REQ-035 SHALL cover a random-stall soak: 1000 cycles with random valid_a and ready_b checked against a reference-model queue -> no loss, duplication or reordering.
